// File: rtl/crc_serial_checker_if.sv
// -----------------------------------------------------------------------------
// crc_serial_checker_if
// Purpose : Groups the serial-bit input handshake and the recovered-frame
//           output handshake of crc_serial_checker.
// Signals : bit_valid/bit_in/sof/bit_ready   - serial codeword input
//           frame_valid/frame_ready          - frame delivery handshake
//           msg_out/crc_ok/err_count         - frame result and error tally
// Modports: master - the serial source plus frame consumer (testbench / link)
//           slave  - the checker itself
// -----------------------------------------------------------------------------
interface crc_serial_checker_if #(
  parameter int MSG_W = 10
);
  logic             bit_valid;
  logic             bit_in;
  logic             sof;
  logic             bit_ready;
  logic             frame_valid;
  logic             frame_ready;
  logic [MSG_W-1:0] msg_out;
  logic             crc_ok;
  logic [7:0]       err_count;

  modport master (
    output bit_valid, bit_in, sof, frame_ready,
    input  bit_ready, frame_valid, msg_out, crc_ok, err_count
  );

  modport slave (
    input  bit_valid, bit_in, sof, frame_ready,
    output bit_ready, frame_valid, msg_out, crc_ok, err_count
  );
endinterface

// File: rtl/crc_serial_checker.sv
// -----------------------------------------------------------------------------
// crc_serial_checker
// Purpose : Receives a serial codeword (MSG_W message bits then CRC_W check
//           bits, MSB first), recomputes the CRC with the same LFSR as the
//           generator and presents the recovered message plus a pass flag.
// Ports   : clk   - rising-edge clock
//           reset - synchronous, active-high
//           bus   - crc_serial_checker_if.slave (bit input + frame output)
// Config  : CRC_CHECK_ERRCNT_EN - when defined, err_count counts delivered
//           frames with crc_ok=0, saturating at 255; otherwise err_count=0.
// -----------------------------------------------------------------------------
module crc_serial_checker #(
  parameter int               MSG_W = 10,
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 8'h07
) (
  input  logic                clk,
  input  logic                reset,
  crc_serial_checker_if.slave bus
);

  localparam int TOTAL = MSG_W + CRC_W;
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_MSG  = CNT_W'(MSG_W);
  localparam logic [CRC_W-1:0] CRC_ZERO = {CRC_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One LFSR step, identical to the generator (no reflection, no final XOR).
  function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] crc,
                                                  input logic             din);
    logic fb;
    fb        = din ^ crc[CRC_W-1];
    lfsr_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : CRC_ZERO);
  endfunction

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [CRC_W-1:0]   crc_q,     crc_d;
  logic [MSG_W-1:0]   msg_sr_q,  msg_sr_d;
  logic [MSG_W-1:0]   msg_out_q, msg_out_d;
  logic               crc_ok_q,  crc_ok_d;

  logic bit_ready_s;
  logic frame_valid_s;
  logic accept_s;
  logic start_s;
  logic deliver_s;

  assign accept_s  = bus.bit_valid && bit_ready_s;
  assign deliver_s = frame_valid_s && bus.frame_ready;
  // An accepted bit opens a new frame from IDLE, or restarts one on sof.
  assign start_s   = accept_s && ((state_q == S_IDLE) || bus.sof);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      crc_q     <= CRC_ZERO;
      msg_sr_q  <= {MSG_W{1'b0}};
      msg_out_q <= {MSG_W{1'b0}};
      crc_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      msg_sr_q  <= msg_sr_d;
      msg_out_q <= msg_out_d;
      crc_ok_q  <= crc_ok_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_SHIFT;
        else          state_d = S_IDLE;
      end
      S_SHIFT: begin
        // A restarting bit resets cnt to 1, so it can never complete a frame.
        if (accept_s && !bus.sof && (cnt_q == CNT_PEN)) state_d = S_DONE;
        else                                            state_d = S_SHIFT;
      end
      S_DONE: begin
        if (deliver_s) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; bit_ready is masked during reset.
  always_comb begin
    bit_ready_s   = 1'b0;
    frame_valid_s = 1'b0;
    case (state_q)
      S_IDLE:  begin bit_ready_s = !reset; frame_valid_s = 1'b0; end
      S_SHIFT: begin bit_ready_s = !reset; frame_valid_s = 1'b0; end
      S_DONE:  begin bit_ready_s = 1'b0;   frame_valid_s = 1'b1; end
      default: begin bit_ready_s = 1'b0;   frame_valid_s = 1'b0; end
    endcase
  end

  // CRC, bit counter and message shift register.
  always_comb begin
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    msg_sr_d = msg_sr_q;
    if (start_s) begin
      crc_d    = lfsr_step(CRC_ZERO, bus.bit_in);
      cnt_d    = CNT_ONE;
      msg_sr_d = {{(MSG_W-1){1'b0}}, bus.bit_in};
    end else if (accept_s) begin
      crc_d = lfsr_step(crc_q, bus.bit_in);
      cnt_d = cnt_q + CNT_ONE;
      // Only the first MSG_W bits are message; the rest are check bits.
      if (cnt_q < CNT_MSG) msg_sr_d = {msg_sr_q[MSG_W-2:0], bus.bit_in};
      else                 msg_sr_d = msg_sr_q;
    end else begin
      crc_d    = crc_q;
      cnt_d    = cnt_q;
      msg_sr_d = msg_sr_q;
    end
  end

  // Frame result, captured once on entry to DONE and held while presented.
  always_comb begin
    msg_out_d = msg_out_q;
    crc_ok_d  = crc_ok_q;
    if ((state_q == S_SHIFT) && (state_d == S_DONE)) begin
      msg_out_d = msg_sr_q;
      crc_ok_d  = (crc_d == CRC_ZERO);
    end else begin
      msg_out_d = msg_out_q;
      crc_ok_d  = crc_ok_q;
    end
  end

`ifdef CRC_CHECK_ERRCNT_EN
  logic [7:0] err_q, err_d;

  // Saturating count of delivered frames that failed the check.
  always_comb begin
    err_d = err_q;
    if (deliver_s && !crc_ok_q && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    else                                            err_d = err_q;
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 8'd0;
    else       err_q <= err_d;
  end

  assign bus.err_count = err_q;
`else
  assign bus.err_count = 8'd0;
`endif

  assign bus.bit_ready   = bit_ready_s;
  assign bus.frame_valid = frame_valid_s;
  assign bus.msg_out     = msg_out_q;
  assign bus.crc_ok      = crc_ok_q;

endmodule

// File: tb/tb_crc_serial_checker.sv
// -----------------------------------------------------------------------------
// tb_crc_serial_checker
// Purpose : Directed, table-driven bench for crc_serial_checker with
//           hand-computed CRC-8 (x^8+x^2+x+1) codewords, plus hand-written
//           sequences for sof restart, reset mid-frame / in DONE and
//           (with CRC_CHECK_ERRCNT_EN) error-counter saturation.
// -----------------------------------------------------------------------------
module tb_crc_serial_checker;

  localparam int MSG_W = 10;
  localparam int CRC_W = 8;
  localparam int TOT   = MSG_W + CRC_W;

  typedef struct {
    logic [TOT-1:0]   cw;
    logic [MSG_W-1:0] msg;
    logic             ok;
    logic             gaps;
    int               hold;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  int   model_err;

  crc_serial_checker_if #(.MSG_W(MSG_W)) bus ();

  crc_serial_checker #(.MSG_W(MSG_W), .CRC_W(CRC_W), .POLY(8'h07)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Starts and ends at a negedge; the bit is accepted at the posedge between.
  task automatic send_bit(input logic b, input logic s);
    int n;
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    bus.sof       = s;
    n = 0;
    while (!bus.bit_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.bit_ready) check("bit_ready_timeout", 32'(bus.bit_ready), 32'd1);
    @(negedge clk);
    bus.bit_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic send_frame(input logic [TOT-1:0] cw, input logic gaps);
    for (int i = TOT - 1; i >= 0; i--) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_bit(cw[i], (i == TOT - 1));
      if (i != 0) check("fv_mid_frame", 32'(bus.frame_valid), 32'd0);
    end
  endtask

  // Called at the negedge right after the last bit was accepted.
  task automatic finish_frame(input logic [MSG_W-1:0] msg, input logic ok, input int hold);
    check("fv_latency", 32'(bus.frame_valid), 32'd1);
    check("br_done", 32'(bus.bit_ready), 32'd0);
    check("msg_out", 32'(bus.msg_out), 32'(msg));
    check("crc_ok", 32'(bus.crc_ok), 32'(ok));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("fv_hold", 32'(bus.frame_valid), 32'd1);
      check("br_hold", 32'(bus.bit_ready), 32'd0);
      check("msg_hold", 32'(bus.msg_out), 32'(msg));
      check("ok_hold", 32'(bus.crc_ok), 32'(ok));
    end
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
    check("fv_after_deliver", 32'(bus.frame_valid), 32'd0);
    check("br_after_deliver", 32'(bus.bit_ready), 32'd1);
`ifdef CRC_CHECK_ERRCNT_EN
    if (!ok && model_err < 255) model_err++;
`endif
    check("err_count", 32'(bus.err_count), 32'(model_err));
  endtask

  vec_t vecs [7];

  initial begin
    checks          = 0;
    fails           = 0;
    model_err       = 0;
    reset           = 1'b1;
    bus.bit_valid   = 1'b0;
    bus.bit_in      = 1'b0;
    bus.sof         = 1'b0;
    bus.frame_ready = 1'b0;

    vecs[0] = '{18'b1100000011_00110110, 10'b1100000011, 1'b1, 1'b0, 0};
    vecs[1] = '{18'b1011001011_01010101, 10'b1011001011, 1'b1, 1'b1, 5};
    vecs[2] = '{18'b1100000011_00110111, 10'b1100000011, 1'b0, 1'b0, 1};
    vecs[3] = '{18'b0000000000_00000000, 10'b0000000000, 1'b1, 1'b0, 0};
    vecs[4] = '{18'b0000000001_00000111, 10'b0000000001, 1'b1, 1'b1, 2};
    vecs[5] = '{18'b0000000001_00000000, 10'b0000000001, 1'b0, 1'b0, 0};
    vecs[6] = '{18'b1011001010_01010101, 10'b1011001010, 1'b0, 1'b1, 3};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_msg_out", 32'(bus.msg_out), 32'd0);
    check("rst_crc_ok", 32'(bus.crc_ok), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_bit_ready", 32'(bus.bit_ready), 32'd1);

    // Table-driven frames.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].hold == 0) bus.frame_ready = 1'b1;
      else                   bus.frame_ready = 1'b0;
      send_frame(vecs[v].cw, vecs[v].gaps);
      finish_frame(vecs[v].msg, vecs[v].ok, vecs[v].hold);
    end

    // sof mid-frame restarts: 7 bits of one frame, then a complete good frame.
    send_bit(1'b1, 1'b1);
    for (int i = TOT - 2; i >= TOT - 7; i--) send_bit(vecs[0].cw[i], 1'b0);
    check("fv_partial", 32'(bus.frame_valid), 32'd0);
    send_frame(vecs[1].cw, 1'b0);
    finish_frame(vecs[1].msg, 1'b1, 0);

    // Reset after 12 bits discards the partial frame and clears err_count.
    for (int i = TOT - 1; i >= TOT - 12; i--) send_bit(vecs[2].cw[i], (i == TOT - 1));
    reset = 1'b1;
    #1;
    check("midrst_bit_ready", 32'(bus.bit_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_err = 0;
    #1;
    check("midrst_fv", 32'(bus.frame_valid), 32'd0);
    check("midrst_br", 32'(bus.bit_ready), 32'd1);
    check("midrst_err", 32'(bus.err_count), 32'd0);
    send_frame(vecs[0].cw, 1'b0);
    finish_frame(vecs[0].msg, 1'b1, 0);

    // frame_ready while idle is ignored; reset while in DONE drops the frame.
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
    check("idle_ready_fv", 32'(bus.frame_valid), 32'd0);
    send_frame(vecs[5].cw, 1'b0);
    check("done_fv", 32'(bus.frame_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("donerst_fv", 32'(bus.frame_valid), 32'd0);
    check("donerst_br", 32'(bus.bit_ready), 32'd1);
    check("donerst_err", 32'(bus.err_count), 32'd0);
    send_frame(vecs[3].cw, 1'b0);
    finish_frame(vecs[3].msg, 1'b1, 0);

`ifdef CRC_CHECK_ERRCNT_EN
    // 260 bad frames: the counter stops at 255.
    for (int f = 0; f < 260; f++) begin
      bus.frame_ready = 1'b1;
      send_frame(vecs[2].cw, 1'b0);
      finish_frame(vecs[2].msg, 1'b0, 0);
    end
    check("err_saturated", 32'(bus.err_count), 32'd255);
`else
    // Without the counter, a bad frame leaves err_count at zero.
    bus.frame_ready = 1'b1;
    send_frame(vecs[2].cw, 1'b0);
    finish_frame(vecs[2].msg, 1'b0, 0);
    check("err_tied_zero", 32'(bus.err_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/crc_serial_checker.md
# crc_serial_checker

Receive-side companion to the serial CRC generator. It takes the serial codeword that the generator produces (MSG_W message bits then CRC_W check bits, MSB first) one bit per handshake and recomputes the CRC with the same LFSR. When the frame is complete it presents the recovered message and a pass/fail flag on an output handshake. It sits directly downstream of the CRC_serial stage, between the serial link and the consumer of message words.

## Interface
- MSG_W, 10, message bits per frame
- CRC_W, 8, CRC width (LFSR length)
- POLY, 8'h07, generator polynomial low CRC_W bits; x^CRC_W implicit (default x^8+x^2+x+1)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- bit_valid  in  1  bit_in valid
- bit_in  in  1  codeword bit, MSB first, message then CRC
- sof  in  1  start-of-frame marker, qualified by bit_valid
- bit_ready  out  1  checker can accept a bit
- frame_valid  out  1  msg_out/crc_ok valid, held until accepted
- frame_ready  in  1  consumer accepts frame
- msg_out  out  MSG_W  recovered message, first received bit at MSB
- crc_ok  out  1  1 = remainder zero
- err_count  out  8  saturating count of delivered bad frames

## Operation
- Bit accepted when bit_valid && bit_ready. Frame delivered when frame_valid && frame_ready.
- States: IDLE, SHIFT, DONE.
  - IDLE: bit_ready=1. Accepted bit starts a frame, sof or not. crc seeds from zero plus that bit, cnt=1, go SHIFT.
  - SHIFT: bit_ready=1, one LFSR step per accepted bit.
    - If the accepted bit has sof=1, the frame restarts: crc reseeds from zero plus this bit, cnt=1, msg shift register reloads.
    - On the accepted bit making cnt = MSG_W+CRC_W, go DONE.
  - DONE: bit_ready=0, frame_valid=1. On delivery go IDLE.
- LFSR step: fb = bit_in ^ crc[CRC_W-1]; crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0). Init 0, no reflection, no final XOR. Identical to the generator.
- Message capture: the first MSG_W accepted bits of the frame shift into msg_sr from the LSB. At DONE, msg_out = msg_sr.
- crc_ok = (crc == 0) after all MSG_W+CRC_W bits, registered on entry to DONE.
- Counter cnt is $clog2(MSG_W+CRC_W+1) bits wide. It never wraps: DONE is entered exactly at the terminal count.
- bit_valid low in IDLE/SHIFT: state, cnt and crc hold. Gaps are allowed anywhere in a frame.
- Outputs msg_out and crc_ok are stable for as long as frame_valid is high.

## Timing
- Reset values: state=IDLE, cnt=0, crc=0, msg_out=0, crc_ok=0, frame_valid=0, err_count=0. bit_ready is forced 0 while reset is high.
- bit_ready=1 in the first cycle after reset deasserts.
- Latency: frame_valid rises 1 cycle after the clock edge that accepts the last bit.
- Simultaneous frame_valid && frame_ready: delivery completes that edge. bit_ready=1 the next cycle, giving a minimum 1 dead cycle between frames.
- frame_ready while frame_valid=0: ignored.
- Reset mid-frame or during DONE: the frame is discarded with no delivery and err_count clears.
- Throughput: 1 bit/cycle. One frame per MSG_W+CRC_W+1 cycles at best.

## Configuration
- CRC_CHECK_ERRCNT_EN defined:
  - err_count increments on each delivered frame with crc_ok=0.
  - It saturates at 255 and is cleared only by reset.
- CRC_CHECK_ERRCNT_EN undefined:
  - The counter logic is removed and err_count is tied to 8'd0.
  - The port remains present.

## Test plan
- Reset, then stream 1100000011_00110110 at 1 bit/cycle with frame_ready=1 -> 1 cycle after the 18th bit: frame_valid=1, msg_out=10'b1100000011, crc_ok=1; bit_ready=1 again 2 cycles after the 18th bit.
- Stream 1011001011_01010101 with random bit_valid gaps and frame_ready held low 5 cycles -> frame_valid held 5+ cycles, bit_ready=0 throughout, msg_out=10'b1011001011, crc_ok=1.
- Stream 1100000011_00110111 (last CRC bit flipped) -> crc_ok=0. With CRC_CHECK_ERRCNT_EN, err_count=1 after delivery.
- Send 7 bits of a frame, then assert sof with the first bit of 1011001011_01010101 -> one frame delivered, msg_out=10'b1011001011, crc_ok=1.
- Assert reset after 12 bits, then send a full good frame -> no frame delivered for the partial one; the good frame reports crc_ok=1.
- With CRC_CHECK_ERRCNT_EN, send 260 bad frames -> err_count saturates at 255.
